// File: rtl/pc_sequencer_if.sv
// Program-memory fetch bus between the sequencer (master) and program memory (slave).
interface pc_sequencer_if;
    logic [7:0] pm_addr;
    logic       pm_req;
    logic       pm_ack;
    logic [7:0] pm_data;

    modport master (output pm_addr, output pm_req, input pm_ack, input pm_data);
    modport slave  (input pm_addr, input pm_req, output pm_ack, output pm_data);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches an instruction from program memory, issues it
// to the decoder for one cycle, executes it (pc update, retire count) and supports
// halt / single-step control plus a sticky fetch-timeout error.
module pc_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                sync_reset_n,
    pc_sequencer_if.master      pm,
    input  logic                jmp,
    input  logic                jmp_nz,
    input  logic [3:0]          ir_nibble,
    input  logic                zero,
    output logic [7:0]          next_instr,
    output logic                exec,
    input  logic                halt,
    input  logic                step,
    output logic                pm_err,
    output logic [1:0]          state,
    output logic [15:0]         retired
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [7:0] NOP = 8'hC8;

    // Counter only needs to hold 0..TIMEOUT-1: the cycle it would reach TIMEOUT
    // is the cycle the fetch is declared failed.
    localparam int          CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q,    state_d;
    logic [7:0]    pc_q,       pc_d;
    logic [7:0]    ibuf_q,     ibuf_d;
    logic [CW-1:0] wait_q,     wait_d;
    logic          err_q,      err_d;
    logic          step_lat_q, step_lat_d;
    logic [15:0]   retired_q,  retired_d;

    // Next-state, pc, instruction-buffer and counter computation.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; without this the tool infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        ibuf_d     = ibuf_q;
        wait_d     = wait_q;
        err_d      = err_q;
        step_lat_d = step_lat_q;
        retired_d  = retired_q;

        case (state_q)
            S_FETCH: begin
                if (pm.pm_ack) begin
                    // An ack on the final allowed cycle still counts as success.
                    ibuf_d  = pm.pm_data;
                    wait_d  = '0;
                    state_d = S_ISSUE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    wait_d  = '0;
                    state_d = S_HALTED;
                end else begin
                    wait_d  = wait_q + CW'(1);
                end
            end
            S_ISSUE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // jmp wins when both jump controls are set.
                if (jmp || (jmp_nz && !zero)) begin
                    pc_d = {ir_nibble, 4'h0};
                end else begin
                    pc_d = pc_q + 8'd1;
                end
                if (retired_q != 16'hFFFF) begin
                    retired_d = retired_q + 16'd1;
                end
                if (halt || step_lat_q) begin
                    step_lat_d = 1'b0;
                    state_d    = S_HALTED;
                end else begin
                    state_d    = S_FETCH;
                end
            end
            default: begin
                // HALTED: a step pulse runs exactly one instruction; an error
                // keeps the sequencer parked until reset except for steps.
                if (step) begin
                    step_lat_d = 1'b1;
                    state_d    = S_FETCH;
                end else if (!halt && !err_q) begin
                    state_d    = S_FETCH;
                end
            end
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!sync_reset_n) begin
            state_q    <= S_FETCH;
            pc_q       <= 8'h00;
            wait_q     <= '0;
            err_q      <= 1'b0;
            step_lat_q <= 1'b0;
            retired_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            step_lat_q <= step_lat_d;
            retired_q  <= retired_d;
        end
    end

    // Instruction buffer: pure datapath register, loaded on each successful fetch.
    always_ff @(posedge clk) begin
        // NOTE: no reset here on purpose; the buffer is only visible in ISSUE,
        // which is always preceded by a capture, so its power-up value is unseen.
        ibuf_q <= ibuf_d;
    end

    assign pm.pm_req  = (state_q == S_FETCH);
    assign pm.pm_addr = pc_q;
    assign next_instr = (state_q == S_ISSUE) ? ibuf_q : NOP;
    assign exec       = (state_q == S_EXEC);
    assign pm_err     = err_q;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule
